inst_queue: RTL

Fetch-to-decode instruction queue. Accepts up to four in-order instructions per cycle from the fetch stage and presents up to two per cycle to the decoders (slot 0 to `decode0`, slot 1 to `decode1`). It is the producer for the decode stage, which in turn feeds the decode/rename pipeline registers. It absorbs the 4-wide fetch versus 2-wide decode rate mismatch and raises a pause request to fetch when it cannot guarantee space for a full fetch group.

---
 rtl/inst_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: accepts up to 4 in-order instructions
// per cycle and presents up to 2 per cycle to the decoders.
// Latency: 1 cycle from enqueue edge to visibility on out_*. No comb path in->out.
// Backpressure: pause_req (from registered count) when fewer than 4 slots are
// free; the fetch group is then dropped and must be re-presented. pause holds decode.
// Ports: clk/rst (async active-low) | flush, pause | in_valid/in_inst/in_pc
// (4 slots, bit 0 oldest) | pause_req | out_valid/out_inst/out_pc (2 slots).
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int IW    = 32,
    parameter int PW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              pause,
    input  logic [3:0]        in_valid,
    input  logic [4*IW-1:0]   in_inst,
    input  logic [4*PW-1:0]   in_pc,
    output logic              pause_req,
    output logic [1:0]        out_valid,
    output logic [2*IW-1:0]   out_inst,
    output logic [2*PW-1:0]   out_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_THR = CW'(DEPTH - 4);

    logic [IW-1:0] inst_mem [DEPTH];
    logic [PW-1:0] pc_mem   [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [2:0]    nin;
    logic [2:0]    nin_acc;
    logic [1:0]    nout;
    logic          enq_ok;
    logic [AW-1:0] head_p1;

    // Only the contiguous run of valid bits from slot 0 counts; anything after
    // the first gap is ignored so program order can never develop a hole.
    always_comb begin
        nin = 3'd0;
        casez (in_valid)
            4'b???0: nin = 3'd0;
            4'b??01: nin = 3'd1;
            4'b?011: nin = 3'd2;
            4'b0111: nin = 3'd3;
            4'b1111: nin = 3'd4;
            default: nin = 3'd0;
        endcase
    end

    // Equivalent to (DEPTH - count) < 4, purely from registered state.
    assign pause_req = (count_q > FULL_THR);
    assign enq_ok    = !pause_req;
    assign nin_acc   = enq_ok ? nin : 3'd0;

    assign out_valid[0] = (count_q != '0);
    assign out_valid[1] = (count_q >= CW'(2));
    assign nout         = pause ? 2'd0 : (2'(out_valid[0]) + 2'(out_valid[1]));

    // Pointers are AW bits wide, so power-of-two DEPTH makes wrap implicit.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(nout);
            tail_d  = tail_q + AW'(nin_acc);
            count_d = count_q + CW'(nin_acc) - CW'(nout);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset. Writes during a flush land beyond the reset
    // pointers and are simply overwritten later.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nin_acc) begin
                inst_mem[tail_q + AW'(i)] <= in_inst[i*IW +: IW];
                pc_mem[tail_q + AW'(i)]   <= in_pc[i*PW +: PW];
            end
        end
    end

    assign head_p1  = head_q + AW'(1);
    assign out_inst = {inst_mem[head_p1], inst_mem[head_q]};
    assign out_pc   = {pc_mem[head_p1],   pc_mem[head_q]};

endmodule
